// File: rtl/op_issue_ctrl.sv
// op_issue_ctrl: pops one op bundle, waits out the queue read latency,
// then steps through its elements one per cycle under a downstream stall.
module op_issue_ctrl #(
    parameter int CONFIG_OP_WIDTH   = 32,
    parameter int LEN_WIDTH         = 12,
    parameter int COMMON_BRAM_DELAY = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_en,
    input  logic                       i_empty,
    input  logic [CONFIG_OP_WIDTH-1:0] i_op_config,
    input  logic                       i_stall,
    output logic                       o_pop,
    output logic                       o_op_valid,
    output logic                       o_first,
    output logic                       o_last,
    output logic [LEN_WIDTH-1:0]       o_elem_idx,
    output logic [LEN_WIDTH-1:0]       o_len,
    output logic                       o_busy
);

    // Latency counter only has to hold COMMON_BRAM_DELAY-1.
    localparam int LAT_W = (COMMON_BRAM_DELAY > 1) ? $clog2(COMMON_BRAM_DELAY) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(COMMON_BRAM_DELAY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_POP,
        S_WAIT,
        S_ISSUE
    } state_e;

    state_e               state_q, state_d;
    logic [LAT_W-1:0]     lat_q, lat_d;
    logic [LEN_WIDTH-1:0] idx_q, idx_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;

    // Bits of the config op above the length field belong to other consumers.
    generate
        if (CONFIG_OP_WIDTH > LEN_WIDTH) begin : g_cfg_unused
            logic cfg_unused;
            assign cfg_unused = ^i_op_config[CONFIG_OP_WIDTH-1:LEN_WIDTH];
        end
    endgenerate

    // State, latency counter, element counter and latched length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
        end
    end

    // Next-state logic plus pop/valid strobes; the last element is compared
    // before incrementing so an all-ones length never wraps the counter.
    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        idx_d      = idx_q;
        len_d      = len_q;
        o_pop      = 1'b0;
        o_op_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_en && !i_empty) begin
                    state_d = S_POP;
                end
            end
            S_POP: begin
                o_pop   = 1'b1;
                lat_d   = LAT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == '0) begin
                    len_d   = i_op_config[LEN_WIDTH-1:0];
                    idx_d   = '0;
                    state_d = S_ISSUE;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            S_ISSUE: begin
                o_op_valid = !i_stall;
                if (!i_stall) begin
                    if (idx_q != len_q) begin
                        idx_d = idx_q + 1'b1;
                    end else if (i_en && !i_empty) begin
                        state_d = S_POP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_first    = o_op_valid && (idx_q == '0);
    assign o_last     = o_op_valid && (idx_q == len_q);
    assign o_elem_idx = idx_q;
    assign o_len      = len_q;
    assign o_busy     = (state_q != S_IDLE);

endmodule
